// File: rtl/ft245_pkg.sv
// Shared constants for the FT245 synchronous-FIFO responder: ERR_FLAGS bit positions
// and the FIFO occupancy-count width helper.
package ft245_pkg;

    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;
    localparam int ERR_BUS = 2;

    // Count width: holds 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ft245_sync_fifo.sv
// Single-clock FIFO with registered storage, combinational head and occupancy count.
// The caller qualifies push/pop; this block does not guard against over/underflow.
module ft245_sync_fifo
    import ft245_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic [WIDTH-1:0]          i_din,
    output logic [WIDTH-1:0]          o_head,
    output logic [cnt_w(DEPTH)-1:0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Storage is not reset; pointers alone define validity.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointer and occupancy update.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1'b1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1'b1);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ft245_sync_responder.sv
// FT2232H-side model of the FT245 synchronous FIFO bus, with host-side byte streams.
// Optional feature: define FT245_SEND_IMMEDIATE_EN to hold TX bytes until SI# or a full packet.
module ft245_sync_responder
    import ft245_pkg::*;
#(
    parameter int RX_DEPTH     = 16,
    parameter int TX_DEPTH     = 16,
    parameter int TX_PKT_BYTES = 8
) (
    input  logic       CLK_FTDI,
    input  logic       RST_N,
    input  logic       READ_N,
    input  logic       WRITE_N,
    input  logic       OUT_EN,
    input  logic       SEND_IM,
    input  logic [7:0] DATA_IN,
    output logic [7:0] DATA_OUT,
    output logic       DATA_OE,
    output logic       GUI_WR_SP_RD_FF,
    output logic       GUI_RD_SP_WR_EF,
    input  logic [7:0] HOST_IN_DATA,
    input  logic       HOST_IN_VALID,
    output logic       HOST_IN_READY,
    output logic [7:0] HOST_OUT_DATA,
    output logic       HOST_OUT_VALID,
    input  logic       HOST_OUT_READY,
    output logic [2:0] ERR_FLAGS
);

    localparam int RX_CW = cnt_w(RX_DEPTH);
    localparam int TX_CW = cnt_w(TX_DEPTH);
    localparam logic [RX_CW-1:0] RX_FULL = RX_CW'(RX_DEPTH);
    localparam logic [TX_CW-1:0] TX_FULL = TX_CW'(TX_DEPTH);

    logic [RX_CW-1:0] w_rx_count;
    logic [RX_CW-1:0] w_rx_count_next;
    logic [TX_CW-1:0] w_tx_count;
    logic [TX_CW-1:0] w_tx_count_next;
    logic             w_rx_push;
    logic             w_rx_pop;
    logic             w_rd_req;
    logic             w_wr_req;
    logic             w_tx_push;
    logic             w_tx_pop;
    logic             w_bus_err;
    logic [2:0]       w_err_set;

    logic             r_rxf_n;
    logic             r_txe_n;
    logic             r_data_oe;
    logic [2:0]       r_err;

    assign HOST_IN_READY = (w_rx_count != RX_FULL);
    assign w_rx_push     = HOST_IN_VALID & HOST_IN_READY;
    assign w_rd_req      = ~OUT_EN & ~READ_N;
    assign w_rx_pop      = w_rd_req & (w_rx_count != '0);

    // A write while the model owns the bus is contention, never a push.
    assign w_bus_err     = ~OUT_EN & ~WRITE_N;
    assign w_wr_req      = ~WRITE_N & OUT_EN;
    assign w_tx_push     = w_wr_req & (w_tx_count != TX_FULL);
    assign w_tx_pop      = HOST_OUT_VALID & HOST_OUT_READY;

    assign w_rx_count_next = w_rx_count + RX_CW'(w_rx_push) - RX_CW'(w_rx_pop);
    assign w_tx_count_next = w_tx_count + TX_CW'(w_tx_push) - TX_CW'(w_tx_pop);

    always_comb begin
        w_err_set          = 3'b000;
        w_err_set[ERR_OVF] = w_wr_req & (w_tx_count == TX_FULL);
        w_err_set[ERR_UNF] = w_rd_req & (w_rx_count == '0);
        w_err_set[ERR_BUS] = w_bus_err;
    end

    ft245_sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
        .i_clk   (CLK_FTDI),
        .i_rst_n (RST_N),
        .i_push  (w_rx_push),
        .i_pop   (w_rx_pop),
        .i_din   (HOST_IN_DATA),
        .o_head  (DATA_OUT),
        .o_count (w_rx_count)
    );

    ft245_sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
        .i_clk   (CLK_FTDI),
        .i_rst_n (RST_N),
        .i_push  (w_tx_push),
        .i_pop   (w_tx_pop),
        .i_din   (DATA_IN),
        .o_head  (HOST_OUT_DATA),
        .o_count (w_tx_count)
    );

    // Status flags track the post-edge counts; errors are sticky until reset.
    always_ff @(posedge CLK_FTDI) begin
        if (!RST_N) begin
            r_rxf_n   <= 1'b1;
            r_txe_n   <= 1'b1;
            r_data_oe <= 1'b0;
            r_err     <= 3'b000;
        end else begin
            r_rxf_n   <= (w_rx_count_next == '0);
            r_txe_n   <= (w_tx_count_next == TX_FULL);
            r_data_oe <= ~OUT_EN;
            r_err     <= r_err | w_err_set;
        end
    end

    assign GUI_WR_SP_RD_FF = r_rxf_n;
    assign GUI_RD_SP_WR_EF = r_txe_n;
    assign DATA_OE         = r_data_oe;
    assign ERR_FLAGS       = r_err;

`ifdef FT245_SEND_IMMEDIATE_EN
    localparam logic [TX_CW-1:0] TX_PKT = TX_CW'(TX_PKT_BYTES);

    logic             r_si_q;
    logic [TX_CW-1:0] r_rel_cnt;
    logic [TX_CW-1:0] w_rel_after_pop;
    logic [TX_CW-1:0] w_unrel_next;
    logic [TX_CW-1:0] w_rel_next;
    logic             w_si_fall;

    assign w_si_fall       = r_si_q & ~SEND_IM;
    assign w_rel_after_pop = r_rel_cnt - TX_CW'(w_tx_pop);
    assign w_unrel_next    = w_tx_count_next - w_rel_after_pop;

    // Release everything on SI# falling or when a full packet is pending.
    always_comb begin
        w_rel_next = w_rel_after_pop;
        if (w_si_fall || (w_unrel_next >= TX_PKT)) begin
            w_rel_next = w_tx_count_next;
        end else begin
            w_rel_next = w_rel_after_pop;
        end
    end

    // SI# edge history and released-byte count.
    always_ff @(posedge CLK_FTDI) begin
        if (!RST_N) begin
            r_si_q    <= 1'b1;
            r_rel_cnt <= '0;
        end else begin
            r_si_q    <= SEND_IM;
            r_rel_cnt <= w_rel_next;
        end
    end

    assign HOST_OUT_VALID = (r_rel_cnt != '0);
`else
    logic w_unused;
    assign w_unused       = SEND_IM | (TX_PKT_BYTES == 0);
    assign HOST_OUT_VALID = (w_tx_count != '0);
`endif

endmodule

// File: tb/tb_ft245_sync_responder.sv
// Directed self-checking bench for ft245_sync_responder (default 16/16/8 parameters).
// Exercises the FT245_SEND_IMMEDIATE_EN path when that macro is defined for the build.
module tb_ft245_sync_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       read_n, write_n, out_en, send_im;
    logic [7:0] data_in, data_out;
    logic       data_oe, rxf_n, txe_n;
    logic [7:0] host_in_data;
    logic       host_in_valid, host_in_ready;
    logic [7:0] host_out_data;
    logic       host_out_valid, host_out_ready;
    logic [2:0] err_flags;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ft245_sync_responder #(.RX_DEPTH(16), .TX_DEPTH(16), .TX_PKT_BYTES(8)) dut (
        .CLK_FTDI        (clk),
        .RST_N           (rst_n),
        .READ_N          (read_n),
        .WRITE_N         (write_n),
        .OUT_EN          (out_en),
        .SEND_IM         (send_im),
        .DATA_IN         (data_in),
        .DATA_OUT        (data_out),
        .DATA_OE         (data_oe),
        .GUI_WR_SP_RD_FF (rxf_n),
        .GUI_RD_SP_WR_EF (txe_n),
        .HOST_IN_DATA    (host_in_data),
        .HOST_IN_VALID   (host_in_valid),
        .HOST_IN_READY   (host_in_ready),
        .HOST_OUT_DATA   (host_out_data),
        .HOST_OUT_VALID  (host_out_valid),
        .HOST_OUT_READY  (host_out_ready),
        .ERR_FLAGS       (err_flags)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; read_n = 1'b1; write_n = 1'b1; out_en = 1'b1; send_im = 1'b1;
        data_in = 8'h00; host_in_data = 8'h00; host_in_valid = 1'b0; host_out_ready = 1'b0;
        tick(); tick();
        chk("rst_rxf", 32'(rxf_n), 32'd1);
        chk("rst_txe", 32'(txe_n), 32'd1);
        chk("rst_oe", 32'(data_oe), 32'd0);
        chk("rst_err", 32'(err_flags), 32'd0);
        chk("rst_hov", 32'(host_out_valid), 32'd0);
        chk("rst_hir", 32'(host_in_ready), 32'd1);
        rst_n = 1'b1;
        tick();
        chk("txe_fall", 32'(txe_n), 32'd0);
        chk("rxf_idle", 32'(rxf_n), 32'd1);

        // RX: host pushes A5, 5A; master reads both
        host_in_valid = 1'b1; host_in_data = 8'hA5; tick();
        host_in_data = 8'h5A; tick();
        host_in_valid = 1'b0;
        chk("rx_rxf_low", 32'(rxf_n), 32'd0);
        chk("rx_head0", 32'(data_out), 32'hA5);
        out_en = 1'b0; tick();
        chk("oe_on", 32'(data_oe), 32'd1);
        read_n = 1'b0;
        chk("rd_byte0", 32'(data_out), 32'hA5);
        tick();
        chk("rd_byte1", 32'(data_out), 32'h5A);
        chk("rd_rxf_mid", 32'(rxf_n), 32'd0);
        tick();
        chk("rd_rxf_high", 32'(rxf_n), 32'd1);
        read_n = 1'b1; out_en = 1'b1; tick();
        chk("oe_off", 32'(data_oe), 32'd0);
        chk("rd_err", 32'(err_flags), 32'd0);

        // TX: 16 writes fill, 17th overflows
        write_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            data_in = 8'(i);
            tick();
            if (i == 14) chk("txe_15", 32'(txe_n), 32'd0);
        end
        chk("txe_full", 32'(txe_n), 32'd1);
        chk("tx_err_none", 32'(err_flags), 32'd0);
        data_in = 8'hEE; tick();
        write_n = 1'b1;
        chk("tx_ovf", 32'(err_flags), 32'b001);
        chk("txe_still", 32'(txe_n), 32'd1);
`ifdef FT245_SEND_IMMEDIATE_EN
        chk("tx_hov", 32'(host_out_valid), 32'd1);
`endif
        host_out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("tx_drain_v", 32'(host_out_valid), 32'd1);
            chk("tx_drain_d", 32'(host_out_data), 32'(i));
            tick();
        end
        host_out_ready = 1'b0;
        chk("tx_empty_v", 32'(host_out_valid), 32'd0);
        chk("tx_empty_txe", 32'(txe_n), 32'd0);

        // Reset mid-burst with RX holding bytes and TX holding one
        write_n = 1'b0; data_in = 8'h42; tick();
        write_n = 1'b1;
        host_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            host_in_data = 8'(8'h60 + i);
            tick();
        end
        host_in_valid = 1'b0;
        out_en = 1'b0; tick();
        read_n = 1'b0; tick();
        rst_n = 1'b0; tick();
        chk("mrst_rxf", 32'(rxf_n), 32'd1);
        chk("mrst_oe", 32'(data_oe), 32'd0);
        chk("mrst_err", 32'(err_flags), 32'd0);
        chk("mrst_hov", 32'(host_out_valid), 32'd0);
        chk("mrst_hir", 32'(host_in_ready), 32'd1);
        rst_n = 1'b1; read_n = 1'b1; out_en = 1'b1; tick();
        chk("mrst_txe", 32'(txe_n), 32'd0);

        // Underrun: RD# with RX empty must not move the read pointer
        out_en = 1'b0; tick();
        read_n = 1'b0; tick();
        chk("unf_err", 32'(err_flags), 32'b010);
        chk("unf_rxf", 32'(rxf_n), 32'd1);
        read_n = 1'b1;
        host_in_valid = 1'b1; host_in_data = 8'h3C; tick();
        host_in_valid = 1'b0;
        chk("unf_head", 32'(data_out), 32'h3C);

        // Contention: OE# and WR# low together; read side still pops
        write_n = 1'b0; data_in = 8'h77; read_n = 1'b0; tick();
        write_n = 1'b1; read_n = 1'b1;
        chk("bus_err", 32'(err_flags), 32'b110);
        chk("bus_rd_pop", 32'(rxf_n), 32'd1);
        chk("bus_txe", 32'(txe_n), 32'd0);
        chk("bus_hov", 32'(host_out_valid), 32'd0);

        // RX full: simultaneous push and pop refuses push, takes pop
        host_in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            host_in_data = 8'(8'h10 + i);
            tick();
        end
        chk("rxfull_hir", 32'(host_in_ready), 32'd0);
        host_in_data = 8'hFF; read_n = 1'b0; tick();
        host_in_valid = 1'b0;
        chk("rxfull_hir2", 32'(host_in_ready), 32'd1);
        for (int i = 1; i < 16; i++) begin
            chk("rxfull_d", 32'(data_out), 32'(8'h10 + i));
            tick();
        end
        read_n = 1'b1;
        chk("rxfull_rxf", 32'(rxf_n), 32'd1);
        out_en = 1'b1; tick();

        // TX full: write plus host pop in the same cycle drops the write
        write_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            data_in = 8'(8'h20 + i);
            tick();
        end
        chk("txfull_txe", 32'(txe_n), 32'd1);
        data_in = 8'hEE; host_out_ready = 1'b1; tick();
        write_n = 1'b1;
        chk("txfull_err", 32'(err_flags), 32'b111);
        chk("txfull_txe2", 32'(txe_n), 32'd0);
        for (int i = 1; i < 16; i++) begin
            chk("txfull_d", 32'(host_out_data), 32'(8'h20 + i));
            tick();
        end
        chk("txfull_empty", 32'(host_out_valid), 32'd0);
        host_out_ready = 1'b0;

`ifdef FT245_SEND_IMMEDIATE_EN
        write_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_in = 8'(8'h80 + i);
            tick();
        end
        write_n = 1'b1;
        chk("si_hold", 32'(host_out_valid), 32'd0);
        send_im = 1'b0; tick();
        send_im = 1'b1;
        chk("si_release", 32'(host_out_valid), 32'd1);
        host_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("si_d", 32'(host_out_data), 32'(8'h80 + i));
            tick();
        end
        host_out_ready = 1'b0;
        chk("si_done", 32'(host_out_valid), 32'd0);
        write_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            data_in = 8'(8'h90 + i);
            tick();
            if (i == 6) chk("pkt_hold7", 32'(host_out_valid), 32'd0);
        end
        write_n = 1'b1;
        chk("pkt_release8", 32'(host_out_valid), 32'd1);
        host_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("pkt_d", 32'(host_out_data), 32'(8'h90 + i));
            tick();
        end
        host_out_ready = 1'b0;
        chk("pkt_done", 32'(host_out_valid), 32'd0);
`else
        send_im = 1'b0; write_n = 1'b0; data_in = 8'h55; tick();
        send_im = 1'b1; write_n = 1'b1;
        chk("nosi_valid", 32'(host_out_valid), 32'd1);
        chk("nosi_d", 32'(host_out_data), 32'h55);
        host_out_ready = 1'b1; tick();
        host_out_ready = 1'b0;
        chk("nosi_done", 32'(host_out_valid), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
